e203_icb2axi_bridge: RTL and testbench

//  Converts the 32-bit ICB system-memory port of the E203 subsystem into a single-beat AXI master
//  of parametrised data width (32 or 64). Tracks up to OUTS_DEPTH outstanding transactions and

---
 rtl/e203_icb2axi_bridge.sv | 226 ++++++++++++++++++++++
 tb/tb_e203_icb2axi_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_icb2axi_bridge.sv
// E203 ICB to single-beat AXI master bridge.
// Commands are accepted one at a time. The AXI address and write-data channels
// are registered. Responses travel combinationally from R/B back to ICB, in order.
// Accepting reads and writes together while requests are outstanding is not
// allowed, so the R and B streams never interleave.
module e203_icb2axi_bridge #(
  parameter int AW         = 32,
  parameter int AXI_DW     = 64,
  parameter int OUTS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  // ICB command channel
  input  logic                icb_cmd_valid,
  output logic                icb_cmd_ready,
  input  logic [AW-1:0]       icb_cmd_addr,
  input  logic                icb_cmd_read,
  input  logic [31:0]         icb_cmd_wdata,
  input  logic [3:0]          icb_cmd_wmask,
  // ICB response channel
  output logic                icb_rsp_valid,
  input  logic                icb_rsp_ready,
  output logic                icb_rsp_err,
  output logic [31:0]         icb_rsp_rdata,
  // AXI read address channel
  output logic                axi_arvalid,
  input  logic                axi_arready,
  output logic [AW-1:0]       axi_araddr,
  output logic [3:0]          axi_arlen,
  output logic [2:0]          axi_arsize,
  output logic [1:0]          axi_arburst,
  output logic [1:0]          axi_arlock,
  output logic [3:0]          axi_arcache,
  output logic [2:0]          axi_arprot,
  // AXI write address channel
  output logic                axi_awvalid,
  input  logic                axi_awready,
  output logic [AW-1:0]       axi_awaddr,
  output logic [3:0]          axi_awlen,
  output logic [2:0]          axi_awsize,
  output logic [1:0]          axi_awburst,
  output logic [1:0]          axi_awlock,
  output logic [3:0]          axi_awcache,
  output logic [2:0]          axi_awprot,
  // AXI write data channel
  output logic                axi_wvalid,
  input  logic                axi_wready,
  output logic [AXI_DW-1:0]   axi_wdata,
  output logic [AXI_DW/8-1:0] axi_wstrb,
  output logic                axi_wlast,
  // AXI read data channel
  input  logic                axi_rvalid,
  output logic                axi_rready,
  input  logic [AXI_DW-1:0]   axi_rdata,
  input  logic [1:0]          axi_rresp,
  input  logic                axi_rlast,
  // AXI write response channel
  input  logic                axi_bvalid,
  output logic                axi_bready,
  input  logic [1:0]          axi_bresp
);

  localparam int PTR_W = $clog2(OUTS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = AXI_DW / 8;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTS_DEPTH);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

  logic [CNT_W-1:0]      cnt_r;
  logic                  dir_r;        // 1 = read direction outstanding
  logic                  ar_valid_r;
  logic                  aw_valid_r;
  logic                  w_valid_r;
  logic [AW-1:0]         ar_addr_r;
  logic [AW-1:0]         aw_addr_r;
  logic [AXI_DW-1:0]     w_data_r;
  logic [SW-1:0]         w_strb_r;
  logic [OUTS_DEPTH-1:0] lane_mem_r;   // addr[2] of each outstanding request
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;

  logic                  cnt_empty_s;
  logic                  cmd_ready_s;
  logic                  accept_s;
  logic                  rsp_valid_s;
  logic                  rsp_hs_s;
  logic [AXI_DW-1:0]     wdata_pack_s;
  logic [SW-1:0]         wstrb_pack_s;
  logic [31:0]           rdata_sel_s;
  logic                  unused_s;

  assign cnt_empty_s = (cnt_r == ZERO_C);
  assign cmd_ready_s = (cnt_r < DEPTH_C) & ~ar_valid_r & ~aw_valid_r & ~w_valid_r
                     & (cnt_empty_s | (icb_cmd_read == dir_r));
  assign accept_s    = icb_cmd_valid & cmd_ready_s;
  assign rsp_valid_s = ~cnt_empty_s & (dir_r ? axi_rvalid : axi_bvalid);
  assign rsp_hs_s    = rsp_valid_s & icb_rsp_ready;

  // Lane placement of the 32-bit ICB data inside the AXI data bus
  generate
    if (AXI_DW == 64) begin : g_dw64
      assign wdata_pack_s = {icb_cmd_wdata, icb_cmd_wdata};
      assign wstrb_pack_s = icb_cmd_addr[2] ? {icb_cmd_wmask, 4'h0} : {4'h0, icb_cmd_wmask};
      assign rdata_sel_s  = lane_mem_r[rd_ptr_r] ? axi_rdata[63:32] : axi_rdata[31:0];
    end else begin : g_dw32
      logic unused_lane_s;
      assign wdata_pack_s  = icb_cmd_wdata;
      assign wstrb_pack_s  = icb_cmd_wmask;
      assign rdata_sel_s   = axi_rdata[31:0];
      assign unused_lane_s = ^{lane_mem_r, rd_ptr_r};
    end
  endgenerate

  // Single-beat responses: rlast and the low resp bits carry no information here
  assign unused_s = ^{axi_rlast, axi_rresp[0], axi_bresp[0]};

  // Read address channel: load on accepted read, hold until arready
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_valid_r <= 1'b0;
      ar_addr_r  <= {AW{1'b0}};
    end else if (accept_s & icb_cmd_read) begin
      ar_valid_r <= 1'b1;
      ar_addr_r  <= icb_cmd_addr;
    end else if (axi_arready) begin
      ar_valid_r <= 1'b0;
    end
  end

  // Write address channel: load on accepted write, retire on awready independently of W
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_valid_r <= 1'b0;
      aw_addr_r  <= {AW{1'b0}};
    end else if (accept_s & ~icb_cmd_read) begin
      aw_valid_r <= 1'b1;
      aw_addr_r  <= icb_cmd_addr;
    end else if (axi_awready) begin
      aw_valid_r <= 1'b0;
    end
  end

  // Write data channel: load on accepted write, retire on wready independently of AW
  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid_r <= 1'b0;
      w_data_r  <= {AXI_DW{1'b0}};
      w_strb_r  <= {SW{1'b0}};
    end else if (accept_s & ~icb_cmd_read) begin
      w_valid_r <= 1'b1;
      w_data_r  <= wdata_pack_s;
      w_strb_r  <= wstrb_pack_s;
    end else if (axi_wready) begin
      w_valid_r <= 1'b0;
    end
  end

  // Outstanding counter and current direction
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= ZERO_C;
      dir_r <= 1'b1;
    end else begin
      case ({accept_s, rsp_hs_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (accept_s) begin
        dir_r <= icb_cmd_read;
      end
    end
  end

  // Lane FIFO pointers; occupancy always equals cnt_r, so no separate level tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (rsp_hs_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Lane FIFO storage; contents are meaningless until written behind the write pointer
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lane_mem_r[wr_ptr_r] <= icb_cmd_addr[2];
    end
  end

  assign icb_cmd_ready = cmd_ready_s;
  assign icb_rsp_valid = rsp_valid_s;
  assign icb_rsp_err   = dir_r ? axi_rresp[1] : axi_bresp[1];
  assign icb_rsp_rdata = rdata_sel_s;
  assign axi_rready    = ~cnt_empty_s & dir_r & icb_rsp_ready;
  assign axi_bready    = ~cnt_empty_s & ~dir_r & icb_rsp_ready;

  assign axi_arvalid = ar_valid_r;
  assign axi_araddr  = ar_addr_r;
  assign axi_awvalid = aw_valid_r;
  assign axi_awaddr  = aw_addr_r;
  assign axi_wvalid  = w_valid_r;
  assign axi_wdata   = w_data_r;
  assign axi_wstrb   = w_strb_r;
  assign axi_wlast   = 1'b1;

  assign axi_arlen   = 4'h0;
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;
  assign axi_arlock  = 2'b00;
  assign axi_arcache = 4'b0000;
  assign axi_arprot  = 3'b000;
  assign axi_awlen   = 4'h0;
  assign axi_awsize  = 3'b010;
  assign axi_awburst = 2'b01;
  assign axi_awlock  = 2'b00;
  assign axi_awcache = 4'b0000;
  assign axi_awprot  = 3'b000;

endmodule

// File: tb/tb_e203_icb2axi_bridge.sv
// Directed bench for e203_icb2axi_bridge (AW=32, AXI_DW=64, OUTS_DEPTH=4).
// Expected AR/AW/W payloads and ICB responses are queued when stimulus is
// issued. A negedge monitor pops and compares them on each handshake.
module tb_e203_icb2axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        axi_arvalid, axi_arready, axi_awvalid, axi_awready;
  logic [31:0] axi_araddr, axi_awaddr;
  logic [3:0]  axi_arlen, axi_awlen, axi_arcache, axi_awcache;
  logic [2:0]  axi_arsize, axi_awsize, axi_arprot, axi_awprot;
  logic [1:0]  axi_arburst, axi_awburst, axi_arlock, axi_awlock;
  logic        axi_wvalid, axi_wready, axi_wlast;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_rvalid, axi_rready, axi_rlast;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp, axi_bresp;
  logic        axi_bvalid, axi_bready;

  int errors = 0;
  int checks = 0;

  logic [31:0] ar_q[$];
  logic [31:0] aw_q[$];
  logic [71:0] w_q[$];    // {wstrb, wdata}
  logic [33:0] rsp_q[$];  // {is_read, err, rdata}

  e203_icb2axi_bridge dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_err(icb_rsp_err),
    .icb_rsp_rdata(icb_rsp_rdata),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arlock(axi_arlock), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awlock(axi_awlock), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before direct sampling
  task automatic settle();
    #1;
  endtask

  // Offer one ICB command and wait (bounded) until it is accepted
  task automatic issue(input logic rd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] wm);
    logic done;
    done = 1'b0;
    icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = a;
    icb_cmd_wdata = wd;   icb_cmd_wmask = wm;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (icb_cmd_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    icb_cmd_valid = 1'b0;
    chk("cmd_accept", {71'd0, done}, 72'd1);
  endtask

  // Scoreboard monitor: compares every handshake against the queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (axi_arvalid && axi_arready) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 72'd1, 72'd0);
        else chk("araddr", {40'd0, axi_araddr}, {40'd0, ar_q.pop_front()});
      end
      if (axi_awvalid && axi_awready) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 72'd1, 72'd0);
        else chk("awaddr", {40'd0, axi_awaddr}, {40'd0, aw_q.pop_front()});
      end
      if (axi_wvalid && axi_wready) begin
        if (w_q.size() == 0) chk("w_unexpected", 72'd1, 72'd0);
        else chk("wdata_wstrb", {axi_wstrb, axi_wdata}, w_q.pop_front());
      end
      if (icb_rsp_valid && icb_rsp_ready) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 72'd1, 72'd0);
        else begin
          logic [33:0] e;
          e = rsp_q.pop_front();
          chk("rsp_err", {71'd0, icb_rsp_err}, {71'd0, e[32]});
          if (e[33]) chk("rsp_rdata", {40'd0, icb_rsp_rdata}, {40'd0, e[31:0]});
        end
      end
    end
  end

  logic [31:0] t3_addr [4];
  logic [31:0] t3_exp  [4];

  initial begin
    rst = 1'b1; icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = 32'd0;
    icb_cmd_wdata = 32'd0; icb_cmd_wmask = 4'd0; icb_rsp_ready = 1'b1;
    axi_arready = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
    axi_rvalid = 1'b0; axi_rdata = 64'd0; axi_rresp = 2'b00; axi_rlast = 1'b1;
    axi_bvalid = 1'b0; axi_bresp = 2'b00;
    tick(); tick();
    rst = 1'b0;
    settle();

    // 1: reset state, constants, read with upper-lane data
    chk("rst_arvalid", {71'd0, axi_arvalid}, 72'd0);
    chk("rst_awvalid", {71'd0, axi_awvalid}, 72'd0);
    chk("rst_wvalid",  {71'd0, axi_wvalid},  72'd0);
    chk("rst_cmd_ready", {71'd0, icb_cmd_ready}, 72'd1);
    chk("rst_rsp_valid", {71'd0, icb_rsp_valid}, 72'd0);
    chk("const_attr", {axi_arlen, axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot,
                       axi_awlen, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_wlast},
        {4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000, 4'h0, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000, 1'b1});
    ar_q.push_back(32'h8000_0004);
    issue(1'b1, 32'h8000_0004, 32'd0, 4'd0);
    settle();
    chk("t1_arvalid", {71'd0, axi_arvalid}, 72'd1);
    axi_arready = 1'b1; tick(); axi_arready = 1'b0;
    rsp_q.push_back({1'b1, 1'b0, 32'h1111_2222});
    axi_rvalid = 1'b1; axi_rdata = 64'h1111_2222_3333_4444;
    tick(); axi_rvalid = 1'b0;

    // 2: write, AW retires three cycles before W
    aw_q.push_back(32'h8000_0000);
    w_q.push_back({8'h03, 64'hDEADBEEF_DEADBEEF});
    issue(1'b0, 32'h8000_0000, 32'hDEAD_BEEF, 4'b0011);
    axi_awready = 1'b1; tick(); axi_awready = 1'b0;
    settle();
    chk("t2_aw_retired", {70'd0, axi_awvalid, axi_wvalid}, 72'b01);
    tick(); tick();
    axi_wready = 1'b1; tick(); axi_wready = 1'b0;
    settle();
    chk("t2_w_retired", {71'd0, axi_wvalid}, 72'd0);
    rsp_q.push_back({1'b0, 1'b0, 32'd0});
    axi_bvalid = 1'b1; tick(); axi_bvalid = 1'b0;

    // 3: four outstanding reads, fifth stalls, in-order lane-correct return
    t3_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
    t3_exp  = '{32'hB000_0000, 32'hA000_0001, 32'hB000_0002, 32'hA000_0003};
    axi_arready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ar_q.push_back(t3_addr[i]);
      issue(1'b1, t3_addr[i], 32'd0, 4'd0);
    end
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h110;
    settle();
    chk("t3_stall_a", {71'd0, icb_cmd_ready}, 72'd0);
    tick(); settle();
    chk("t3_stall_b", {71'd0, icb_cmd_ready}, 72'd0);
    tick();
    icb_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsp_q.push_back({1'b1, 1'b0, t3_exp[i]});
      axi_rvalid = 1'b1;
      axi_rdata = {32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i)};
      tick();
    end
    axi_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    settle();
    chk("t3_idle_rready", {70'd0, axi_rready, icb_rsp_valid}, 72'd0);
    chk("t3_idle_ready", {71'd0, icb_cmd_ready}, 72'd1);
    axi_rvalid = 1'b0;

    // 4: write offered behind an outstanding read must wait for the read response
    ar_q.push_back(32'h200);
    issue(1'b1, 32'h200, 32'd0, 4'd0);
    tick();
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = 32'h8000_0004;
    settle();
    chk("t4_stall_a", {71'd0, icb_cmd_ready}, 72'd0);
    tick();
    rsp_q.push_back({1'b1, 1'b0, 32'h89AB_CDEF});
    axi_rvalid = 1'b1; axi_rdata = 64'h0123_4567_89AB_CDEF;
    settle();
    chk("t4_stall_rsp_cycle", {71'd0, icb_cmd_ready}, 72'd0);
    tick(); axi_rvalid = 1'b0;
    aw_q.push_back(32'h8000_0004);
    w_q.push_back({8'hC0, 64'h12345678_12345678});
    axi_awready = 1'b1; axi_wready = 1'b1;
    issue(1'b0, 32'h8000_0004, 32'h1234_5678, 4'b1100);
    tick();
    axi_awready = 1'b0; axi_wready = 1'b0;

    // 5: error responses and backpressure
    icb_rsp_ready = 1'b0; axi_bvalid = 1'b1; axi_bresp = 2'b10;
    settle();
    chk("t5_bready_bp", {70'd0, axi_bready, icb_rsp_valid}, 72'b01);
    chk("t5_berr", {71'd0, icb_rsp_err}, 72'd1);
    tick(); tick();
    rsp_q.push_back({1'b0, 1'b1, 32'd0});
    icb_rsp_ready = 1'b1;
    tick(); axi_bvalid = 1'b0; axi_bresp = 2'b00;
    ar_q.push_back(32'h300);
    issue(1'b1, 32'h300, 32'd0, 4'd0);
    tick();
    icb_rsp_ready = 1'b0; axi_rvalid = 1'b1; axi_rresp = 2'b11;
    axi_rdata = 64'h5555_6666_7777_8888;
    settle();
    chk("t5_rready_bp", {70'd0, axi_rready, icb_rsp_valid}, 72'b01);
    tick();
    rsp_q.push_back({1'b1, 1'b1, 32'h7777_8888});
    icb_rsp_ready = 1'b1;
    tick(); axi_rvalid = 1'b0; axi_rresp = 2'b00;

    // 6: reset with two reads outstanding and AR pending
    axi_arready = 1'b0;
    issue(1'b1, 32'h400, 32'd0, 4'd0);
    ar_q.push_back(32'h400);
    axi_arready = 1'b1; tick(); axi_arready = 1'b0;
    issue(1'b1, 32'h404, 32'd0, 4'd0);
    settle();
    chk("t6_pre_arvalid", {71'd0, axi_arvalid}, 72'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    axi_rvalid = 1'b1; axi_rdata = 64'h9999_9999_9999_9999;
    settle();
    chk("t6_arvalid", {71'd0, axi_arvalid}, 72'd0);
    chk("t6_cmd_ready", {71'd0, icb_cmd_ready}, 72'd1);
    chk("t6_cnt_zero", {70'd0, axi_rready, icb_rsp_valid}, 72'd0);
    axi_rvalid = 1'b0;
    ar_q.push_back(32'h404);
    axi_arready = 1'b1;
    issue(1'b1, 32'h404, 32'd0, 4'd0);
    tick(); axi_arready = 1'b0;
    rsp_q.push_back({1'b1, 1'b0, 32'hCAFE_F00D});
    axi_rvalid = 1'b1; axi_rdata = 64'hCAFEF00D_0BADBEEF;
    tick(); axi_rvalid = 1'b0;
    tick();

    chk("ar_q_drained",  72'(ar_q.size()),  72'd0);
    chk("aw_q_drained",  72'(aw_q.size()),  72'd0);
    chk("w_q_drained",   72'(w_q.size()),   72'd0);
    chk("rsp_q_drained", 72'(rsp_q.size()), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
